// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//   Packs decoded RV32I instruction fields plus a 32-bit immediate into a
//   32-bit instruction word, paired with an auto-incrementing instruction
//   memory byte address, so a loader can stream programs into imem.
//   One output register with a valid/ready handshake on each side.
//
// Optional feature (compile-time macro INST_ENCODER_RANGE_CHECK_EN):
//   when defined, each word carries a registered range-error flag and a
//   sticky error flag is kept; when undefined both outputs are constant 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   fmt                 000 I, 001 B, 010 J, 011 S, 100 U, 101 shift-imm,
//                       110/111 illegal (emits NOP)
//   opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   addr_load/addr_val  load the address counter
//   err_clr             clear err_sticky
//   out_valid/out_ready output handshake
//   inst_out            encoded word
//   inst_addr           current address counter value
//   err_out             range error for the current inst_out
//   err_sticky          error seen on any output handshake
// ---------------------------------------------------------------------------
module inst_encoder #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    input  logic              err_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              err_out,
    output logic              err_sticky
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Field packing; immediate bits outside each format are simply dropped.
    function automatic logic [31:0] pack_word(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        logic [31:0] w;
        case (f)
            3'b000:  w = {im[11:0], s1, f3, d, op};
            3'b001:  w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            3'b010:  w = {im[20], im[10:1], im[11], im[19:12], d, op};
            3'b011:  w = {im[11:5], s2, s1, f3, im[4:0], op};
            3'b100:  w = {im[31:12], d, op};
            3'b101:  w = {f7, im[4:0], s1, f3, d, op};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    logic              vld_p1;
    logic [31:0]       inst_p1;
    logic [ADDR_W-1:0] addr_q;
    logic              take;
    logic              out_fire;

    assign in_ready  = !vld_p1 || out_ready;
    assign take      = in_valid && in_ready;
    assign out_fire  = vld_p1 && out_ready;
    assign out_valid = vld_p1;
    assign inst_out  = inst_p1;
    assign inst_addr = addr_q;

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst)
            inst_p1 <= '0;
        else if (take)
            inst_p1 <= pack_word(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
    end

    // Counter addresses the word currently presented; a load beats an increment.
    always_ff @(posedge clk) begin
        if (rst)
            addr_q <= BASE_ADDR;
        else if (addr_load)
            addr_q <= addr_val;
        else if (out_fire)
            addr_q <= addr_q + ADDR_W'(4);
    end

`ifdef INST_ENCODER_RANGE_CHECK_EN
    // An immediate is in range when the bits the format drops are pure
    // sign extension (or zero, for U low bits / shift amount high bits).
    function automatic logic range_err(input logic [2:0] f, input logic [31:0] im);
        logic e;
        case (f)
            3'b000, 3'b011: e = !(&im[31:11] || ~|im[31:11]);
            3'b001:         e = !(&im[31:12] || ~|im[31:12]) || im[0];
            3'b010:         e = !(&im[31:20] || ~|im[31:20]) || im[0];
            3'b100:         e = |im[11:0];
            3'b101:         e = |im[31:5];
            default:        e = 1'b1;
        endcase
        return e;
    endfunction

    logic err_p1;
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_p1 <= 1'b0;
        else if (take)
            err_p1 <= range_err(fmt, imm);
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)
            sticky_q <= 1'b0;
        else if (out_fire && err_p1)
            sticky_q <= 1'b1;
        else if (err_clr)
            sticky_q <= 1'b0;
    end

    assign err_out    = err_p1;
    assign err_sticky = sticky_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_out        = 1'b0;
    assign err_sticky     = 1'b0;
`endif

endmodule
